cla_addsub_pipe: RTL

Two-stage pipelined 32-bit carry-lookahead adder/subtractor for the integer execute path. It generates the per-bit propagate/generate vectors that the 2-bit lookahead cells consume. It resolves them through a tree of those cells and forms the sum from the returned carries. Operands enter and results leave through valid/ready handshakes, sustaining one operation per cycle under no backpressure.

---
 rtl/cla_addsub_pipe_if.sv | 30 +++
 rtl/cla_addsub_pipe.sv | 113 +++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bundle for cla_addsub_pipe
//   master : operand producer and result consumer
//   slave  : the adder/subtractor pipeline
//   in_valid/in_ready   operand handshake, a/b/sub/trap_op travel with in_valid
//   out_valid/out_ready result handshake, sum/cout/ovf/zero/trap travel with out_valid
interface cla_addsub_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        trap_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        trap;

    modport master (
        output in_valid, a, b, sub, trap_op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, trap
    );

    modport slave (
        input  in_valid, a, b, sub, trap_op, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, trap
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined 32-bit carry-lookahead adder/subtractor
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, empties both stages and clears outputs
//   bus    cla_addsub_pipe_if.slave: operands a, b, sub, trap_op in on in_valid/in_ready;
//          sum, cout, ovf, zero, trap out on out_valid/out_ready
// Stage 1 registers per-bit propagate/generate; stage 2 resolves the carries through a
// tree of 2-bit pg cells (2/4/8/16/32-bit spans, then back-propagation) and registers
// the result.
// Build option ADDSUB_OVF_TRAP_EN: when defined, trap = ovf & trap_op registered with the
// result; when undefined, trap is tied to 0 and trap_op is ignored.
module cla_addsub_pipe (
    input logic              clk,
    input logic              rst_n,
    cla_addsub_pipe_if.slave bus
);
    logic        s1_valid, s2_valid, s1_adv, s2_adv;
    logic [31:0] b_eff, s1_p, s1_g;
    logic        s1_c0;
    logic [1:0]  pg [32];
    logic [32:0] c;
    logic [31:0] sum_d, sum_q;
    logic        ovf_d, cout_q, ovf_q, zero_q;

    // Combines a high group with the adjacent lower group: {P, G}
    function automatic logic [1:0] pg_cell(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] & lo[1], hi[0] | (hi[1] & lo[0])};
    endfunction

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_c0    <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_p  <= bus.a ^ b_eff;
                s1_g  <= bus.a & b_eff;
                s1_c0 <= bus.sub;
            end
        end
    end

    // Brent-Kung style prefix tree worked in place. The carry-in is folded into bit 0's
    // generate, so every prefix G[j:0] is directly c[j+1].
    always_comb begin
        for (int j = 0; j < 32; j++) pg[j] = {s1_p[j], s1_g[j]};
        pg[0][0] = s1_g[0] | (s1_p[0] & s1_c0);
        // Up-sweep: node j at level l covers span 2^l ending at bit j.
        for (int l = 1; l <= 5; l++)
            for (int j = 0; j < 32; j++)
                if ((j + 1) % (1 << l) == 0)
                    pg[j] = pg_cell(pg[j], pg[j - (1 << (l - 1))]);
        // Back-propagation: extend each partial node with the finished prefix just below it.
        for (int l = 5; l >= 1; l--)
            for (int j = 0; j < 32; j++)
                if (j >= (1 << l) && (j + 1) % (1 << l) == (1 << (l - 1)))
                    pg[j] = pg_cell(pg[j], pg[j - (1 << (l - 1))]);
        c[0] = s1_c0;
        for (int j = 0; j < 32; j++) c[j + 1] = pg[j][0];
    end

    assign sum_d = s1_p ^ c[31:0];
    assign ovf_d = c[31] ^ c[32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_adv) begin
                sum_q  <= sum_d;
                cout_q <= c[32];
                ovf_q  <= ovf_d;
                zero_q <= ~|sum_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

`ifdef ADDSUB_OVF_TRAP_EN
    logic s1_trap_op, trap_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_trap_op <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            if (bus.in_ready && bus.in_valid) s1_trap_op <= bus.trap_op;
            if (s1_adv) trap_q <= ovf_d & s1_trap_op;
        end
    end

    assign bus.trap = trap_q & s2_valid;
`else
    assign bus.trap = 1'b0;
`endif
endmodule
